// File: rtl/frame_dump_ctrl.sv
// Frame counter driven by vsync falling edges with a
// start/length dump window FSM, cleared by ROM download.
module frame_dump_ctrl #(
  parameter int unsigned START_FRAME = 0,
  parameter int unsigned DUMP_FRAMES = 0,
  parameter int unsigned SYNC_VS     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs,
  input  logic        dwnld,
  output logic [31:0] frame_cnt,
  output logic        frame_stb,
  output logic        dump_en,
  output logic        dump_start,
  output logic        dump_stop,
  output logic [1:0]  st
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } st_e;

  st_e         r_st;
  logic        r_vs_m;
  logic        r_vs_q;
  logic        r_vs_d;
  logic [31:0] r_frame_cnt;
  logic [31:0] r_win;
  logic        r_frame_stb;
  logic        r_dump_en;
  logic        r_dump_start;
  logic        r_dump_stop;

  logic        w_vs_s;
  logic        w_fall;
  logic        w_stb;
  logic        w_open;
  logic        w_close;
  logic [31:0] w_win_nxt;

  assign w_vs_s    = (SYNC_VS != 0) ? r_vs_q : vs;
  assign w_fall    = r_vs_d & ~w_vs_s;
  // download suppresses the strobe even on a coincident edge
  assign w_stb     = w_fall & ~dwnld;
  assign w_win_nxt = r_win + 32'd1;

  assign w_open  = (r_st == WAIT) & w_stb &
                   (r_frame_cnt == START_FRAME);
  assign w_close = (r_st == DUMP) &
                   (dwnld | (w_stb & (DUMP_FRAMES != 0) &
                             (w_win_nxt == DUMP_FRAMES)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_m       <= 1'b0;
      r_vs_q       <= 1'b0;
      r_vs_d       <= 1'b0;
      r_frame_cnt  <= '0;
      r_win        <= '0;
      r_frame_stb  <= 1'b0;
      r_dump_en    <= 1'b0;
      r_dump_start <= 1'b0;
      r_dump_stop  <= 1'b0;
      r_st         <= IDLE;
    end else begin
      r_vs_m       <= vs;
      r_vs_q       <= r_vs_m;
      r_vs_d       <= w_vs_s;
      r_frame_stb  <= w_stb;
      r_dump_start <= w_open;
      r_dump_stop  <= w_close;

      if (dwnld)
        r_frame_cnt <= '0;
      else if (w_stb)
        r_frame_cnt <= r_frame_cnt + 32'd1;

      if (dwnld) begin
        r_st      <= IDLE;
        r_dump_en <= 1'b0;
      end else begin
        unique case (r_st)
          IDLE: r_st <= WAIT;
          WAIT: begin
            if (w_open) begin
              r_st      <= DUMP;
              r_dump_en <= 1'b1;
              r_win     <= '0;
            end
          end
          DUMP: begin
            if (w_close) begin
              r_st      <= DONE;
              r_dump_en <= 1'b0;
            end else if (w_stb) begin
              r_win <= w_win_nxt;
            end
          end
          DONE: r_st <= DONE;
          default: r_st <= IDLE;
        endcase
      end
    end
  end

  assign frame_cnt  = r_frame_cnt;
  assign frame_stb  = r_frame_stb;
  assign dump_en    = r_dump_en;
  assign dump_start = r_dump_start;
  assign dump_stop  = r_dump_stop;
  assign st         = r_st;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Directed bench for frame_dump_ctrl: three parameter sets
// share one stimulus bus; each phase checks one instance.
module tb_frame_dump_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic vs;
  logic dwnld;

  logic [2:0][31:0] cnt;
  logic [2:0]       stb;
  logic [2:0]       en;
  logic [2:0]       start;
  logic [2:0]       stop;
  logic [2:0][1:0]  st;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  frame_dump_ctrl #(.START_FRAME(2), .DUMP_FRAMES(3), .SYNC_VS(1))
  dut_a (
    .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld),
    .frame_cnt(cnt[0]), .frame_stb(stb[0]), .dump_en(en[0]),
    .dump_start(start[0]), .dump_stop(stop[0]), .st(st[0])
  );

  frame_dump_ctrl #(.START_FRAME(0), .DUMP_FRAMES(0), .SYNC_VS(1))
  dut_b (
    .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld),
    .frame_cnt(cnt[1]), .frame_stb(stb[1]), .dump_en(en[1]),
    .dump_start(start[1]), .dump_stop(stop[1]), .st(st[1])
  );

  frame_dump_ctrl #(.START_FRAME(0), .DUMP_FRAMES(1), .SYNC_VS(0))
  dut_c (
    .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld),
    .frame_cnt(cnt[2]), .frame_stb(stb[2]), .dump_en(en[2]),
    .dump_start(start[2]), .dump_stop(stop[2]), .st(st[2])
  );

  typedef struct {
    int          hi;
    logic [31:0] cnt;
    logic        start;
    logic        stop;
    logic        en;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_out(input string nm, input int k,
                         input logic [31:0] c, input logic s,
                         input logic p, input logic e,
                         input logic [1:0] t);
    check({nm, ".cnt"},   cnt[k],   c);
    check({nm, ".start"}, start[k], {31'd0, s});
    check({nm, ".stop"},  stop[k],  {31'd0, p});
    check({nm, ".en"},    en[k],    {31'd0, e});
    check({nm, ".st"},    st[k],    {30'd0, t});
  endtask

  // high for hi cycles, then fall and wait for the strobe
  task automatic pulse(input int k, input int hi, input int lat,
                       input string nm);
    int n;
    n = 0;
    vs = 1'b1;
    repeat (hi) @(negedge clk);
    vs = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!stb[k] && n < 10);
    check({nm, ".lat"}, n, lat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vs    = 1'b0;
    dwnld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int nbad;
    tbl[0] = '{2, 32'd1, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[1] = '{3, 32'd2, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[2] = '{4, 32'd3, 1'b1, 1'b0, 1'b1, 2'd2};
    tbl[3] = '{2, 32'd4, 1'b0, 1'b0, 1'b1, 2'd2};
    tbl[4] = '{5, 32'd5, 1'b0, 1'b0, 1'b1, 2'd2};
    tbl[5] = '{3, 32'd6, 1'b0, 1'b1, 1'b0, 2'd3};
    tbl[6] = '{2, 32'd7, 1'b0, 1'b0, 1'b0, 2'd3};
    tbl[7] = '{4, 32'd8, 1'b0, 1'b0, 1'b0, 2'd3};

    rst_n = 1'b0;
    vs    = 1'b0;
    dwnld = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("rst", 0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("rst.stb", {31'd0, stb[0]}, 32'd0);
    rst_n = 1'b1;
    nbad = 0;
    repeat (4) begin
      @(negedge clk);
      if (stb[0] || stb[1]) nbad++;
    end
    check("no_spur_stb", nbad, 0);

    // START_FRAME=2, DUMP_FRAMES=3 window
    for (int i = 0; i < 8; i++) begin
      pulse(0, tbl[i].hi, 3, $sformatf("a%0d", i));
      chk_out($sformatf("a%0d", i), 0, tbl[i].cnt, tbl[i].start,
              tbl[i].stop, tbl[i].en, tbl[i].st);
      @(negedge clk);
      check($sformatf("a%0d.stb_w", i),
            {29'd0, stb[0], start[0], stop[0]}, 32'd0);
      repeat (2) @(negedge clk);
    end

    // download coincident with edge detection
    do_reset();
    pulse(0, 3, 3, "co0");
    check("co0.cnt", cnt[0], 32'd1);
    vs = 1'b1;
    repeat (3) @(negedge clk);
    vs = 1'b0;
    repeat (2) @(negedge clk);
    dwnld = 1'b1;
    @(negedge clk);
    check("co.stb", {31'd0, stb[0]}, 32'd0);
    check("co.cnt", cnt[0], 32'd0);
    check("co.st", {30'd0, st[0]}, 32'd0);
    @(negedge clk);
    check("co.stb2", {31'd0, stb[0]}, 32'd0);
    dwnld = 1'b0;
    repeat (2) @(negedge clk);

    // download during an open-ended window
    do_reset();
    pulse(1, 3, 3, "b0");
    check("b0.start", {31'd0, start[1]}, 32'd1);
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      pulse(1, 2, 3, $sformatf("b%0d", i));
    end
    chk_out("b6", 1, 32'd7, 1'b0, 1'b0, 1'b1, 2'd2);
    @(negedge clk);
    dwnld = 1'b1;
    @(negedge clk);
    chk_out("dl", 1, 32'd0, 1'b0, 1'b1, 1'b0, 2'd0);
    nbad = 0;
    for (int i = 0; i < 99; i++) begin
      vs = (i % 20) < 10;
      @(negedge clk);
      if (stb[1] || stop[1] || start[1] || cnt[1] != 0 || st[1] != 0)
        nbad++;
    end
    check("dl.hold", nbad, 0);
    vs    = 1'b0;
    dwnld = 1'b0;
    repeat (3) @(negedge clk);
    pulse(1, 3, 3, "reopen");
    chk_out("reopen", 1, 32'd1, 1'b1, 1'b0, 1'b1, 2'd2);

    // counter wrap with preload
    @(negedge clk);
    force dut_b.r_frame_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut_b.r_frame_cnt;
    @(negedge clk);
    check("wrap.pre", cnt[1], 32'hFFFF_FFFE);
    pulse(1, 3, 3, "w0");
    chk_out("w0", 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 2'd2);
    @(negedge clk);
    pulse(1, 3, 3, "w1");
    chk_out("w1", 1, 32'd0, 1'b0, 1'b0, 1'b1, 2'd2);
    @(negedge clk);
    pulse(1, 3, 3, "w2");
    chk_out("w2", 1, 32'd1, 1'b0, 1'b0, 1'b1, 2'd2);

    // async reset mid-window
    do_reset();
    pulse(1, 3, 3, "r0");
    check("r0.en", {31'd0, en[1]}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rmid", 1, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("rmid.stb", {31'd0, stb[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nbad = 0;
    repeat (3) begin
      @(negedge clk);
      if (stb[1] || stop[1]) nbad++;
    end
    check("rrel.quiet", nbad, 0);
    pulse(1, 3, 3, "r1");
    chk_out("r1", 1, 32'd1, 1'b1, 1'b0, 1'b1, 2'd2);

    // unsynchronised vs, one-frame window
    do_reset();
    pulse(2, 3, 1, "c0");
    chk_out("c0", 2, 32'd1, 1'b1, 1'b0, 1'b1, 2'd2);
    repeat (2) @(negedge clk);
    pulse(2, 3, 1, "c1");
    chk_out("c1", 2, 32'd2, 1'b0, 1'b1, 1'b0, 2'd3);
    repeat (2) @(negedge clk);
    pulse(2, 2, 1, "c2");
    chk_out("c2", 2, 32'd3, 1'b0, 1'b0, 1'b0, 2'd3);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/frame_dump_ctrl.md
FRAME_DUMP_CTRL -- requirements
Module: frame_dump_ctrl

Interface
REQ-001 Parameter: START_FRAME, default 0, frame number at which the dump window opens.
REQ-002 Parameter: DUMP_FRAMES, default 0, window length in frames; 0 = never closes.
REQ-003 Parameter: SYNC_VS, default 1, 1 = two-flop synchroniser on vs; 0 = vs used directly.
REQ-004 One clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  async active-low reset.
REQ-007 vs  in  1  vertical sync, active high, asynchronous to clk when SYNC_VS=1.
REQ-008 dwnld  in  1  ROM download in progress, active high, synchronous to clk.
REQ-009 frame_cnt  out  32  frames completed since the end of the last download.
REQ-010 frame_stb  out  1  one-cycle pulse on each counted vs falling edge.
REQ-011 dump_en  out  1  level, high while the dump window is open.
REQ-012 dump_start  out  1  one-cycle pulse when the window opens.
REQ-013 dump_stop  out  1  one-cycle pulse when the window closes.
REQ-014 st  out  2  FSM state: 0 IDLE, 1 WAIT, 2 DUMP, 3 DONE.

Function
REQ-015 vs_s is vs after two flops when SYNC_VS=1, else vs; one further flop holds vs_s for edge detection.
REQ-016 Falling edge = previous vs_s high and current vs_s low; frame_stb is registered on it, 3 clk after vs falls (SYNC_VS=1), 1 clk (SYNC_VS=0).
REQ-017 frame_stb asserts only when dwnld is low in the detection cycle; no pulse while dwnld is high.
REQ-018 frame_cnt increments by 1 in the same clock frame_stb goes high; wraps 0xFFFF_FFFF -> 0 with no flag.
REQ-019 frame_cnt clears to 0 on the first cycle dwnld is high and holds 0 while dwnld is high.
REQ-020 IDLE -> WAIT when dwnld is low.
REQ-021 WAIT -> DUMP on a frame_stb cycle whose pre-increment frame_cnt equals START_FRAME; dump_start pulses in that cycle and dump_en rises in it.
REQ-022 START_FRAME=0 opens the window on the first falling edge after the download ends.
REQ-023 In DUMP, an internal 32-bit window counter counts frame_stb pulses after the opening one; the window counter resets to 0 on entry to DUMP.
REQ-024 DUMP -> DONE on the frame_stb that brings the window counter to DUMP_FRAMES (DUMP_FRAMES>0); dump_stop pulses and dump_en falls in that cycle.
REQ-025 DUMP_FRAMES=0: DUMP is never left except by dwnld or reset.
REQ-026 DONE is terminal until dwnld or reset.
REQ-027 dwnld high in any state forces IDLE next cycle.
REQ-028 If dwnld rises while in DUMP, dump_stop pulses and dump_en falls in the cycle it is seen.
REQ-029 If dwnld rises in the same cycle as a falling edge, dwnld wins: no frame_stb, no count, no start.
REQ-030 dump_start and dump_stop are never high in the same cycle; at most one of each per window.
REQ-031 All outputs are registered.

Reset
REQ-032 While rst_n is low: frame_cnt=0, frame_stb=0, dump_en=0, dump_start=0, dump_stop=0, st=IDLE, synchroniser flops=0, window counter=0.
REQ-033 Reset mid-window drops dump_en immediately with no dump_stop pulse.
REQ-034 After rst_n rises with vs low, no spurious frame_stb is produced.

Verification
REQ-035 START_FRAME=2, DUMP_FRAMES=3, SYNC_VS=1, dwnld low, 8 vs pulses -> frame_stb 3 clk after each fall; dump_start on stb with pre-count 2 (frame_cnt 2->3); dump_stop on stb with frame_cnt 5->6.
REQ-036 dwnld high for 100 clk during DUMP at frame_cnt=7 -> dump_stop same cycle; frame_cnt=0 next cycle; st=IDLE; after dwnld falls, window reopens at pre-count START_FRAME.
REQ-037 Preload frame_cnt to 0xFFFF_FFFE via force, DUMP_FRAMES=0, 3 vs edges -> frame_cnt 0xFFFF_FFFF, 0, 1; no flags; dump_en stays in its prior state.
REQ-038 dwnld rise coincident with the vs edge-detect cycle -> no frame_stb, frame_cnt=0, st=IDLE.
REQ-039 rst_n low mid-window (dump_en=1) -> all outputs 0 asynchronously, no dump_stop; after release with START_FRAME=0 the first falling edge produces dump_start.
REQ-040 SYNC_VS=0, START_FRAME=0, DUMP_FRAMES=1 -> frame_stb 1 clk after vs falls; dump_start at the first stb, dump_stop at the second, then st=DONE.
